// File: rtl/gonso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gonso_pkg
// Description : Shared register offsets, bit indices and address decode for
//               the Gonso color-sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package gonso_pkg;

    // Register offsets relative to the block base address
    localparam logic [31:0] GONSO_FIFO_DATA   = 32'h0000_0000;
    localparam logic [31:0] GONSO_FIFO_STATUS = 32'h0000_0004;
    localparam logic [31:0] GONSO_FIFO_CTRL   = 32'h0000_0008;
    localparam logic [31:0] GONSO_FIFO_THRESH = 32'h0000_000C;

    // STATUS register bit positions
    localparam int STATUS_EMPTY_BIT = 16;
    localparam int STATUS_FULL_BIT  = 17;
    localparam int STATUS_OVF_BIT   = 18;
    localparam int STATUS_UDF_BIT   = 19;

    // CTRL register bit positions
    localparam int CTRL_CAP_EN_BIT = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_IRQ_EN_BIT = 2;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } gonso_reg_e;

    typedef struct packed {
        logic       hit;
        gonso_reg_e sel;
    } gonso_dec_t;

    // Map a byte offset onto one of the four registers; anything else misses
    function automatic gonso_dec_t gonso_decode(input logic [31:0] off);
        gonso_dec_t d;
        d.hit = 1'b1;
        d.sel = REG_DATA;
        case (off)
            GONSO_FIFO_DATA:   d.sel = REG_DATA;
            GONSO_FIFO_STATUS: d.sel = REG_STATUS;
            GONSO_FIFO_CTRL:   d.sel = REG_CTRL;
            GONSO_FIFO_THRESH: d.sel = REG_THRESH;
            default:           d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gonso_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gonso_sync_fifo
// Description : Single-clock FIFO with occupancy count, synchronous clear and
//               simultaneous push/pop (push into a full FIFO is allowed when a
//               pop happens on the same edge).
// Revision    : 1.0 - initial release
// ============================================================================
module gonso_sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int DATA_W = 8,
    localparam int CNT_W  = $clog2(DEPTH + 1),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              clear_i,
    input  logic [DATA_W-1:0] din_i,
    output logic [DATA_W-1:0] dout_o,
    output logic [CNT_W-1:0]  count_o,
    output logic [CNT_W-1:0]  count_next_o,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o      = (count_q == '0);
    assign full_o       = (count_q == CNT_W'(DEPTH));
    assign dout_o       = mem_q[rd_ptr_q];
    assign count_o      = count_q;
    assign count_next_o = count_d;

    // A pop frees a slot on the same edge, so a full FIFO still accepts a push
    // alongside it; clear discards any push on its edge.
    assign do_pop  = pop_i && !empty_o && !clear_i;
    assign do_push = push_i && (!full_o || do_pop) && !clear_i;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/gonso_color_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gonso_color_fifo
// Description : Captures valid color samples into a FIFO and exposes it over a
//               Wishbone slave (DATA / STATUS / CTRL / THRESH) with a level
//               threshold interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module gonso_color_fifo
    import gonso_pkg::*;
#(
    parameter  int          DEPTH     = 16,
    parameter  int          DATA_W    = 8,
    parameter  logic [31:0] BASE_ADDR = 32'h3003_0010,
    localparam int          CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] color_in,
    input  logic              color_valid,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic [31:0]       wishbone_address,
    input  logic              wbs_we_i,
    input  logic [31:0]       wbs_dat_i,
    input  logic [3:0]        wbs_sel_i,
    output logic [31:0]       wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              irq
);

    // Registered state
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d;
    logic              irq_q, irq_d;
    logic              cap_en_q, cap_en_d;
    logic              irq_en_q, irq_en_d;
    logic [CNT_W-1:0]  thresh_q, thresh_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;

    // Bus decode
    logic [31:0]       offset;
    gonso_dec_t        dec;
    logic              accept;
    logic              bus_wr;
    logic              pop_req;
    logic              ctrl_wr;
    logic              thresh_wr;
    logic              clear;
    logic              push_req;
    logic [31:0]       rdata;

    // FIFO interface
    logic [DATA_W-1:0] fifo_dout;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  fifo_count_next;
    logic              fifo_full;
    logic              fifo_empty;

    // Write-data and select bits beyond the implemented fields are ignored
    logic              unused_bits;
    assign unused_bits = &{1'b0, wbs_sel_i[3:1], wbs_dat_i};

    assign offset    = wishbone_address - BASE_ADDR;
    assign dec       = gonso_decode(offset);
    assign accept    = wbs_cyc_i && wbs_stb_i && !ack_q && dec.hit;
    assign bus_wr    = accept && wbs_we_i;
    assign pop_req   = accept && !wbs_we_i && (dec.sel == REG_DATA);
    assign ctrl_wr   = bus_wr && (dec.sel == REG_CTRL) && wbs_sel_i[0];
    assign thresh_wr = bus_wr && (dec.sel == REG_THRESH) && wbs_sel_i[0];
    assign clear     = ctrl_wr && wbs_dat_i[CTRL_CLR_BIT];
    assign push_req  = color_valid && cap_en_q;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq       = irq_q;

    gonso_sync_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push_req),
        .pop_i        (pop_req),
        .clear_i      (clear),
        .din_i        (color_in),
        .dout_o       (fifo_dout),
        .count_o      (fifo_count),
        .count_next_o (fifo_count_next),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Read-data mux; values are those present before the accepting edge
    always_comb begin
        rdata = '0;
        case (dec.sel)
            REG_DATA: begin
                if (!fifo_empty) rdata[DATA_W-1:0] = fifo_dout;
            end
            REG_STATUS: begin
                rdata[CNT_W-1:0]        = fifo_count;
                rdata[STATUS_EMPTY_BIT] = fifo_empty;
                rdata[STATUS_FULL_BIT]  = fifo_full;
                rdata[STATUS_OVF_BIT]   = ovf_q;
                rdata[STATUS_UDF_BIT]   = udf_q;
            end
            REG_CTRL: begin
                rdata[CTRL_CAP_EN_BIT] = cap_en_q;
                rdata[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_THRESH: begin
                rdata[CNT_W-1:0] = thresh_q;
            end
            default: rdata = '0;
        endcase
    end

    // Next-state for bus response, control, sticky flags and interrupt
    always_comb begin
        ack_d    = accept;
        dat_d    = accept ? rdata : dat_q;
        cap_en_d = cap_en_q;
        irq_en_d = irq_en_q;
        thresh_d = thresh_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (ctrl_wr) begin
            cap_en_d = wbs_dat_i[CTRL_CAP_EN_BIT];
            irq_en_d = wbs_dat_i[CTRL_IRQ_EN_BIT];
        end
        if (thresh_wr) thresh_d = wbs_dat_i[CNT_W-1:0];

        if (clear) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            // When full, an accepted DATA read always pops, making room
            if (push_req && fifo_full && !pop_req) ovf_d = 1'b1;
            if (pop_req && fifo_empty)             udf_d = 1'b1;
        end

        irq_d = irq_en_q && (fifo_count_next >= thresh_q) && (fifo_count_next != '0);
    end

    // Register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q    <= 1'b0;
            dat_q    <= '0;
            irq_q    <= 1'b0;
            cap_en_q <= 1'b0;
            irq_en_q <= 1'b0;
            thresh_q <= CNT_W'(1);
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            irq_q    <= irq_d;
            cap_en_q <= cap_en_d;
            irq_en_q <= irq_en_d;
            thresh_q <= thresh_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gonso_color_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_gonso_color_fifo
// Description : Self-checking bench for gonso_color_fifo: register vectors
//               from a table plus a sample scoreboard for FIFO traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gonso_color_fifo;

    localparam int          DEPTH  = 16;
    localparam int          DATA_W = 8;
    localparam logic [31:0] BASE   = 32'h3003_0010;
    localparam logic [31:0] O_DATA = 32'h0;
    localparam logic [31:0] O_STAT = 32'h4;
    localparam logic [31:0] O_CTRL = 32'h8;
    localparam logic [31:0] O_THR  = 32'hC;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [DATA_W-1:0] color_in = '0;
    logic              color_valid = 1'b0;
    logic              wbs_cyc_i = 1'b0;
    logic              wbs_stb_i = 1'b0;
    logic [31:0]       wishbone_address = '0;
    logic              wbs_we_i = 1'b0;
    logic [31:0]       wbs_dat_i = '0;
    logic [3:0]        wbs_sel_i = '0;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o;
    logic              irq;

    gonso_color_fifo #(
        .DEPTH     (DEPTH),
        .DATA_W    (DATA_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .color_in         (color_in),
        .color_valid      (color_valid),
        .wbs_cyc_i        (wbs_cyc_i),
        .wbs_stb_i        (wbs_stb_i),
        .wishbone_address (wishbone_address),
        .wbs_we_i         (wbs_we_i),
        .wbs_dat_i        (wbs_dat_i),
        .wbs_sel_i        (wbs_sel_i),
        .wbs_dat_o        (wbs_dat_o),
        .wbs_ack_o        (wbs_ack_o),
        .irq              (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [7:0] sb[$];
    bit         m_cap = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;
    logic       irq_at_ack = 1'b0;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic [31:0] off;
        bit          we;
        logic [31:0] wd;
        logic [3:0]  sel;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        return {12'h0, m_udf, m_ovf, (sb.size() == DEPTH), (sb.size() == 0), 11'h0, 5'(sb.size())};
    endfunction

    // One bus access; drives an optional color sample on the request cycle
    task automatic xfer(input logic [31:0] off, input bit we, input logic [31:0] wd,
                        input logic [3:0] sel, input bit push, input logic [7:0] pd,
                        output logic [31:0] rd, output bit acked);
        @(negedge clk);
        wishbone_address = BASE + off;
        wbs_we_i  = we;
        wbs_dat_i = wd;
        wbs_sel_i = sel;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        if (push) begin
            color_valid = 1'b1;
            color_in    = pd;
        end
        acked = 1'b0;
        rd    = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            color_valid = 1'b0;
            if (wbs_ack_o) begin
                acked      = 1'b1;
                rd         = wbs_dat_o;
                irq_at_ack = irq;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        if (acked) begin
            last_rd = rd;
            @(negedge clk);
            check("ack_pulse", {31'h0, wbs_ack_o}, 32'h0);
        end
    endtask

    task automatic reg_wr(input logic [31:0] off, input logic [31:0] wd, input bit push, input logic [7:0] pd);
        logic [31:0] rd;
        bit          ak;
        xfer(off, 1'b1, wd, 4'h1, push, pd, rd, ak);
        check("wr_ack", {31'h0, ak}, 32'h1);
        if (off == O_CTRL && wd[1]) begin
            sb.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (push && m_cap) begin
            if (sb.size() < DEPTH) sb.push_back(pd);
            else                   m_ovf = 1'b1;
        end
        if (off == O_CTRL) m_cap = wd[0];
    endtask

    task automatic rd_reg(input string name, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        bit          ak;
        xfer(off, 1'b0, 32'h0, 4'hF, 1'b0, 8'h0, rd, ak);
        check({name, "_ack"}, {31'h0, ak}, 32'h1);
        check(name, rd, exp);
    endtask

    task automatic rd_data(input string name, input bit push, input logic [7:0] pd);
        logic [31:0] rd;
        bit          ak;
        logic [7:0]  exp;
        bit          popping;
        popping = (sb.size() > 0);
        exp     = popping ? sb[0] : 8'h00;
        xfer(O_DATA, 1'b0, 32'h0, 4'hF, push, pd, rd, ak);
        check({name, "_ack"}, {31'h0, ak}, 32'h1);
        check(name, rd, {24'h0, exp});
        if (popping) void'(sb.pop_front());
        else         m_udf = 1'b1;
        if (push && m_cap) sb.push_back(pd);
    endtask

    task automatic push_sample(input logic [7:0] d);
        @(negedge clk);
        color_valid = 1'b1;
        color_in    = d;
        @(negedge clk);
        color_valid = 1'b0;
        if (m_cap) begin
            if (sb.size() < DEPTH) sb.push_back(d);
            else                   m_ovf = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        bit          ak;

        vecs[0]  = '{O_STAT, 1'b0, 32'h0,         4'hF, 32'h0001_0000, "rst_status"};
        vecs[1]  = '{O_CTRL, 1'b0, 32'h0,         4'hF, 32'h0,         "rst_ctrl"};
        vecs[2]  = '{O_THR,  1'b0, 32'h0,         4'hF, 32'h1,         "rst_thresh"};
        vecs[3]  = '{O_THR,  1'b1, 32'h7,         4'h1, 32'h0,         "wr_thresh7"};
        vecs[4]  = '{O_THR,  1'b0, 32'h0,         4'hF, 32'h7,         "thresh_rb"};
        vecs[5]  = '{O_THR,  1'b1, 32'h9,         4'h2, 32'h0,         "wr_thresh_nosel"};
        vecs[6]  = '{O_THR,  1'b0, 32'h0,         4'hF, 32'h7,         "thresh_sel0"};
        vecs[7]  = '{O_THR,  1'b1, 32'h25,        4'h1, 32'h0,         "wr_thresh_wide"};
        vecs[8]  = '{O_THR,  1'b0, 32'h0,         4'hF, 32'h5,         "thresh_mask"};
        vecs[9]  = '{O_CTRL, 1'b1, 32'hFFFF_FFF4, 4'h1, 32'h0,         "wr_ctrl_irqen"};
        vecs[10] = '{O_CTRL, 1'b0, 32'h0,         4'hF, 32'h4,         "ctrl_rb"};
        vecs[11] = '{O_STAT, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'h0,         "wr_status"};
        vecs[12] = '{O_STAT, 1'b0, 32'h0,         4'hF, 32'h0001_0000, "status_ro"};
        vecs[13] = '{O_CTRL, 1'b1, 32'h0,         4'h1, 32'h0,         "wr_ctrl0"};
        vecs[14] = '{O_THR,  1'b1, 32'h1,         4'h1, 32'h0,         "wr_thresh1"};
        vecs[15] = '{O_THR,  1'b0, 32'h0,         4'hF, 32'h1,         "thresh_restore"};

        repeat (3) @(negedge clk);
        check("rst_ack", {31'h0, wbs_ack_o}, 32'h0);
        check("rst_dat", wbs_dat_o, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst = 1'b0;

        // Register vectors
        for (int i = 0; i < 16; i++) begin
            xfer(vecs[i].off, vecs[i].we, vecs[i].wd, vecs[i].sel, 1'b0, 8'h0, rd, ak);
            check({vecs[i].name, "_ack"}, {31'h0, ak}, 32'h1);
            if (!vecs[i].we) check(vecs[i].name, rd, vecs[i].exp);
        end

        // Basic capture and drain
        reg_wr(O_CTRL, 32'h1, 1'b0, 8'h0);
        push_sample(8'hA1);
        push_sample(8'hB2);
        push_sample(8'hC3);
        rd_reg("status_3", O_STAT, m_status());
        for (int i = 0; i < 3; i++) rd_data("drain3", 1'b0, 8'h0);
        rd_reg("status_empty", O_STAT, 32'h0001_0000);

        // Overfill: the 17th sample is dropped
        for (int i = 0; i < 17; i++) push_sample(8'(i));
        rd_reg("status_ovf_full", O_STAT, 32'h0006_0010);
        for (int i = 0; i < DEPTH; i++) rd_data("drain16", 1'b0, 8'h0);
        rd_reg("status_after_drain", O_STAT, 32'h0005_0000);

        // Full FIFO with push coinciding with pop
        reg_wr(O_CTRL, 32'h3, 1'b0, 8'h0);
        rd_reg("status_cleared", O_STAT, 32'h0001_0000);
        for (int i = 0; i < DEPTH; i++) push_sample(8'h20 + 8'(i));
        rd_data("full_pushpop", 1'b1, 8'h55);
        rd_reg("status_full_pp", O_STAT, 32'h0002_0010);
        for (int i = 0; i < DEPTH; i++) rd_data("drain_pp", 1'b0, 8'h0);
        rd_reg("status_pp_empty", O_STAT, m_status());

        // Threshold interrupt
        reg_wr(O_THR, 32'h4, 1'b0, 8'h0);
        reg_wr(O_CTRL, 32'h5, 1'b0, 8'h0);
        for (int i = 0; i < 3; i++) begin
            push_sample(8'h60 + 8'(i));
            check("irq_below", {31'h0, irq}, 32'h0);
        end
        push_sample(8'h63);
        check("irq_rise", {31'h0, irq}, 32'h1);
        rd_data("irq_pop", 1'b0, 8'h0);
        check("irq_fall", {31'h0, irq_at_ack}, 32'h0);
        for (int i = 0; i < 3; i++) rd_data("irq_drain", 1'b0, 8'h0);

        // Threshold zero: irq tracks not-empty
        reg_wr(O_THR, 32'h0, 1'b0, 8'h0);
        check("irq_t0_empty", {31'h0, irq}, 32'h0);
        push_sample(8'h71);
        check("irq_t0_one", {31'h0, irq}, 32'h1);
        rd_data("irq_t0_pop", 1'b0, 8'h0);
        check("irq_t0_fall", {31'h0, irq_at_ack}, 32'h0);

        // Underflow, then clear with a same-cycle push
        reg_wr(O_CTRL, 32'h1, 1'b0, 8'h0);
        reg_wr(O_THR, 32'h1, 1'b0, 8'h0);
        rd_data("udf_read", 1'b0, 8'h0);
        rd_reg("status_udf", O_STAT, 32'h0009_0000);
        reg_wr(O_CTRL, 32'h3, 1'b1, 8'h99);
        rd_reg("status_clr_push", O_STAT, 32'h0001_0000);
        rd_reg("ctrl_after_clr", O_CTRL, 32'h1);
        push_sample(8'h77);
        rd_reg("status_cap_on", O_STAT, 32'h0000_0001);
        rd_data("cap_on_data", 1'b0, 8'h0);

        // Unmatched address: never acked, read data held
        xfer(32'h10, 1'b0, 32'h0, 4'hF, 1'b0, 8'h0, rd, ak);
        check("bad_addr_ack", {31'h0, ak}, 32'h0);
        check("bad_addr_hold", wbs_dat_o, last_rd);

        // Reset in the middle of a request
        push_sample(8'h88);
        push_sample(8'h89);
        @(negedge clk);
        wishbone_address = BASE + O_DATA;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        rst       = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", {31'h0, wbs_ack_o}, 32'h0);
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_cap = 1'b0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        rd_reg("status_rst_mid", O_STAT, 32'h0001_0000);
        rd_reg("ctrl_rst_mid", O_CTRL, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
